// File: rtl/cache_pkg.sv
// Shared cache geometry, refill state encoding and line-address helper.
// Used by the data cache and its miss-handling stage.
package cache_pkg;

   localparam int BLOCK_SIZE    = 32;
   localparam int WORDS         = BLOCK_SIZE / 4;
   localparam int OFFSET_BITS   = $clog2(BLOCK_SIZE);
   localparam int WORD_IDX_BITS = $clog2(WORDS);
   localparam int ADDR_W        = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WB   = 2'd1,
      RD   = 2'd2,
      DONE = 2'd3
   } refill_state_e;

   function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/refill_beat_tracker.sv
// Counts issued and returned read beats of one refill, enforces the
// outstanding-read limit and generates critical-word-first wrapped indices.
module refill_beat_tracker
   import cache_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     i_start,
   input  logic [WORD_IDX_BITS-1:0] i_crit,
   input  logic                     i_iss,
   input  logic                     i_rsp,
   output logic                     o_can_issue_next,
   output logic [WORD_IDX_BITS-1:0] o_next_idx,
   output logic [WORD_IDX_BITS-1:0] o_rsp_idx,
   output logic                     o_rsp_pending,
   output logic                     o_rsp_first,
   output logic                     o_rsp_last
);

   localparam int CNT_W = WORD_IDX_BITS + 1;
   localparam logic [CNT_W-1:0] C_WORDS = CNT_W'(WORDS);
   localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(WORDS - 1);
   localparam logic [CNT_W-1:0] C_MAX   = CNT_W'(MAX_OUTSTANDING);

   logic [CNT_W-1:0]         r_iss_cnt;
   logic [CNT_W-1:0]         r_rsp_cnt;
   logic [WORD_IDX_BITS-1:0] r_crit;

   logic [CNT_W-1:0] w_iss_nxt;
   logic [CNT_W-1:0] w_rsp_nxt;
   logic [CNT_W-1:0] w_out_nxt;

   // Look-ahead counts include this cycle's handshakes so the registered
   // request valid for next cycle already respects the limit.
   assign w_iss_nxt = r_iss_cnt + CNT_W'(i_iss);
   assign w_rsp_nxt = r_rsp_cnt + CNT_W'(i_rsp);
   assign w_out_nxt = w_iss_nxt - w_rsp_nxt;

   assign o_can_issue_next = (w_iss_nxt < C_WORDS) && (w_out_nxt < C_MAX);
   assign o_next_idx       = r_crit + w_iss_nxt[WORD_IDX_BITS-1:0];
   assign o_rsp_idx        = r_crit + r_rsp_cnt[WORD_IDX_BITS-1:0];
   assign o_rsp_pending    = (r_iss_cnt != r_rsp_cnt);
   assign o_rsp_first      = (r_rsp_cnt == '0);
   assign o_rsp_last       = (r_rsp_cnt == C_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_iss_cnt <= '0;
         r_rsp_cnt <= '0;
         r_crit    <= '0;
      end else if (i_start) begin
         r_iss_cnt <= '0;
         r_rsp_cnt <= '0;
         r_crit    <= i_crit;
      end else begin
         r_iss_cnt <= w_iss_nxt;
         r_rsp_cnt <= w_rsp_nxt;
      end
   end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss handler: optional dirty-victim write-back, then a wrapped
// critical-word-first line fetch streamed into the cache fill port.
module cache_refill_ctrl
   import cache_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     miss_valid,
   output logic                     miss_ready,
   input  logic [ADDR_W-1:0]        miss_addr,
   input  logic                     victim_dirty,
   input  logic [ADDR_W-1:0]        victim_addr,
   output logic [WORD_IDX_BITS-1:0] wb_rd_idx,
   input  logic [31:0]              wb_rd_data,
   output logic                     mem_req_valid,
   input  logic                     mem_req_ready,
   output logic                     mem_req_write,
   output logic [ADDR_W-1:0]        mem_req_addr,
   output logic [31:0]              mem_req_wdata,
   input  logic                     mem_resp_valid,
   input  logic [31:0]              mem_resp_data,
   output logic                     fill_valid,
   output logic [WORD_IDX_BITS-1:0] fill_idx,
   output logic [31:0]              fill_data,
   output logic                     crit_valid,
   output logic [31:0]              crit_data,
   output logic                     refill_done
);

   refill_state_e            r_state;
   logic [WORD_IDX_BITS-1:0] r_wb_cnt;
   logic [ADDR_W-1:0]        r_line_base;

   logic                     w_miss_acc;
   logic                     w_iss_fire;
   logic                     w_rsp_fire;
   logic                     w_can_issue_next;
   logic [WORD_IDX_BITS-1:0] w_next_idx;
   logic [WORD_IDX_BITS-1:0] w_rsp_idx;
   logic                     w_rsp_pending;
   logic                     w_rsp_first;
   logic                     w_rsp_last;
   logic [ADDR_W-1:0]        w_rd_addr;

   assign w_miss_acc = (r_state == IDLE) && miss_valid && miss_ready;
   assign w_iss_fire = (r_state == RD) && mem_req_valid && mem_req_ready;
   // Responses are only meaningful against a read still in flight.
   assign w_rsp_fire = (r_state == RD) && mem_resp_valid && w_rsp_pending;
   assign w_rd_addr  = {r_line_base[ADDR_W-1:OFFSET_BITS], w_next_idx, 2'b00};

   assign wb_rd_idx     = r_wb_cnt;
   assign mem_req_wdata = (r_state == WB) ? wb_rd_data : '0;

   refill_beat_tracker #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) u_tracker (
      .clk              (clk),
      .reset_n          (reset_n),
      .i_start          (w_miss_acc),
      .i_crit           (miss_addr[OFFSET_BITS-1:2]),
      .i_iss            (w_iss_fire),
      .i_rsp            (w_rsp_fire),
      .o_can_issue_next (w_can_issue_next),
      .o_next_idx       (w_next_idx),
      .o_rsp_idx        (w_rsp_idx),
      .o_rsp_pending    (w_rsp_pending),
      .o_rsp_first      (w_rsp_first),
      .o_rsp_last       (w_rsp_last)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= IDLE;
         r_wb_cnt      <= '0;
         r_line_base   <= '0;
         miss_ready    <= 1'b1;
         mem_req_valid <= 1'b0;
         mem_req_write <= 1'b0;
         mem_req_addr  <= '0;
         fill_valid    <= 1'b0;
         fill_idx      <= '0;
         fill_data     <= '0;
         crit_valid    <= 1'b0;
         crit_data     <= '0;
         refill_done   <= 1'b0;
      end else begin
         fill_valid  <= 1'b0;
         crit_valid  <= 1'b0;
         refill_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_miss_acc) begin
                  miss_ready    <= 1'b0;
                  r_line_base   <= line_base(miss_addr);
                  r_wb_cnt      <= '0;
                  mem_req_valid <= 1'b1;
                  if (victim_dirty) begin
                     r_state       <= WB;
                     mem_req_write <= 1'b1;
                     mem_req_addr  <= victim_addr;
                  end else begin
                     r_state       <= RD;
                     mem_req_write <= 1'b0;
                     mem_req_addr  <= {miss_addr[ADDR_W-1:2], 2'b00};
                  end
               end
            end
            WB: begin
               if (mem_req_valid && mem_req_ready) begin
                  if (r_wb_cnt == WORD_IDX_BITS'(WORDS - 1)) begin
                     // Tracker is still at beat 0, so its index is the critical word.
                     r_state       <= RD;
                     mem_req_write <= 1'b0;
                     mem_req_addr  <= w_rd_addr;
                  end else begin
                     r_wb_cnt     <= r_wb_cnt + 1'b1;
                     mem_req_addr <= mem_req_addr + ADDR_W'(4);
                  end
               end
            end
            RD: begin
               if (!mem_req_valid || mem_req_ready) begin
                  mem_req_valid <= w_can_issue_next;
                  if (w_can_issue_next) begin
                     mem_req_addr <= w_rd_addr;
                  end
               end
               if (w_rsp_fire) begin
                  fill_valid <= 1'b1;
                  fill_idx   <= w_rsp_idx;
                  fill_data  <= mem_resp_data;
                  if (w_rsp_first) begin
                     crit_valid <= 1'b1;
                     crit_data  <= mem_resp_data;
                  end
                  if (w_rsp_last) begin
                     refill_done <= 1'b1;
                     r_state     <= DONE;
                  end
               end
            end
            DONE: begin
               r_state    <= IDLE;
               miss_ready <= 1'b1;
            end
            default: begin
               r_state    <= IDLE;
               miss_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: a line-level model queues the expected
// memory beats, fills and critical words; a negedge monitor pops and compares.
module tb_cache_refill_ctrl;

   localparam int MAX_OUT = 4;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   typedef struct {
      logic [2:0]  idx;
      logic [31:0] data;
   } fill_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } rd_t;

   logic        clk;
   logic        reset_n;
   logic        miss_valid;
   logic        miss_ready;
   logic [31:0] miss_addr;
   logic        victim_dirty;
   logic [31:0] victim_addr;
   logic [2:0]  wb_rd_idx;
   logic [31:0] wb_rd_data;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_write;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        fill_valid;
   logic [2:0]  fill_idx;
   logic [31:0] fill_data;
   logic        crit_valid;
   logic [31:0] crit_data;
   logic        refill_done;

   cache_refill_ctrl #(
      .MAX_OUTSTANDING (MAX_OUT)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .miss_valid     (miss_valid),
      .miss_ready     (miss_ready),
      .miss_addr      (miss_addr),
      .victim_dirty   (victim_dirty),
      .victim_addr    (victim_addr),
      .wb_rd_idx      (wb_rd_idx),
      .wb_rd_data     (wb_rd_data),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_write  (mem_req_write),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wdata  (mem_req_wdata),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .fill_valid     (fill_valid),
      .fill_idx       (fill_idx),
      .fill_data      (fill_data),
      .crit_valid     (crit_valid),
      .crit_data      (crit_data),
      .refill_done    (refill_done)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard state
   req_t        exp_req_q[$];
   fill_t       exp_fill_q[$];
   logic [31:0] exp_crit_q[$];
   rd_t         mem_q[$];
   logic [31:0] victim_words[8];
   logic [31:0] data_seed = 32'h1234_5678;
   int          lat = 2;
   bit          rand_ready = 0;
   int          stall_cnt = 0;
   int          stall_rd_at = 0;
   int          stall_wr_at = 0;
   int          spur_cnt = 0;
   int          outstanding = 0;
   int          peak_out = 0;
   int          rd_fires = 0;
   int          wr_fires = 0;
   int          fills_seen = 0;
   int          done_cnt = 0;
   int          exp_done = 0;
   bit          held_v = 0;
   logic [64:0] held;
   int          total = 0;
   int          bad = 0;

   assign wb_rd_data = victim_words[wb_rd_idx];

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ data_seed;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // memory model: ready pattern, in-order read responses after lat cycles
   initial begin
      rd_t r;
      forever begin
         @(posedge clk);
         #1;
         if (stall_rd_at > 0 && rd_fires >= stall_rd_at) begin stall_cnt = 5; stall_rd_at = 0; end
         if (stall_wr_at > 0 && wr_fires >= stall_wr_at) begin stall_cnt = 5; stall_wr_at = 0; end
         if (stall_cnt > 0) begin
            mem_req_ready = 1'b0;
            stall_cnt--;
         end else begin
            mem_req_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         if (spur_cnt > 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = $urandom;
            spur_cnt--;
         end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            r = mem_q.pop_front();
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_fn(r.addr);
            outstanding--;
         end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
         end
      end
   end

   // monitor
   initial begin
      req_t  e;
      fill_t f;
      logic [31:0] c;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            held_v = 0;
            continue;
         end
         if (held_v) begin
            chk("req_held", 64'({mem_req_valid, mem_req_write, mem_req_addr[29:0], mem_req_wdata}),
                64'({1'b1, held[64], held[61:32], held[31:0]}));
            chk("req_held_addr_hi", 64'(mem_req_addr[31:30]), 64'(held[63:62]));
         end
         held_v = mem_req_valid && !mem_req_ready;
         held   = {mem_req_write, mem_req_addr, mem_req_wdata};
         if (mem_req_valid && mem_req_ready) begin
            if (exp_req_q.size() == 0) begin
               chk("req_unexpected", 64'(mem_req_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e = exp_req_q.pop_front();
               chk("req_write", 64'(mem_req_write), 64'(e.wr));
               chk("req_addr", 64'(mem_req_addr), 64'(e.addr));
               if (e.wr) chk("req_wdata", 64'(mem_req_wdata), 64'(e.wdata));
            end
            if (mem_req_write) begin
               wr_fires++;
            end else begin
               rd_fires++;
               outstanding++;
               if (outstanding > peak_out) peak_out = outstanding;
               chk("max_outstanding", 64'(outstanding <= MAX_OUT), 64'(1));
               mem_q.push_back('{addr: mem_req_addr, due: cyc + lat});
            end
         end
         if (fill_valid) begin
            fills_seen++;
            if (exp_fill_q.size() == 0) begin
               chk("fill_unexpected", 64'(fill_idx), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               f = exp_fill_q.pop_front();
               chk("fill_idx", 64'(fill_idx), 64'(f.idx));
               chk("fill_data", 64'(fill_data), 64'(f.data));
            end
         end
         if (crit_valid) begin
            chk("crit_with_fill", 64'(fill_valid), 64'(1));
            if (exp_crit_q.size() == 0) begin
               chk("crit_unexpected", 64'(crit_data), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               c = exp_crit_q.pop_front();
               chk("crit_data", 64'(crit_data), 64'(c));
            end
         end
         if (refill_done) begin
            done_cnt++;
            chk("done_with_last_fill", 64'({fill_valid, 1'b0}) | 64'(exp_fill_q.size()), 64'(2));
         end
      end
   end

   // driver: model the whole line transfer, then present the miss
   task automatic start_miss(input logic [31:0] addr, input bit dirty, input logic [31:0] vaddr,
                             input int latency);
      logic [31:0] base;
      int          crit;
      int          idx;
      bit          got;
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         got = miss_ready;
      end
      chk("miss_ready_wait", 64'(got), 64'(1));
      for (int k = 0; k < 8; k++) victim_words[k] = $urandom;
      lat  = latency;
      base = addr & ~32'd31;
      crit = int'(addr[4:2]);
      if (dirty)
         for (int k = 0; k < 8; k++) exp_req_q.push_back('{wr: 1'b1, addr: vaddr + 32'(4 * k), wdata: victim_words[k]});
      for (int k = 0; k < 8; k++) begin
         idx = (crit + k) % 8;
         exp_req_q.push_back('{wr: 1'b0, addr: base + 32'(4 * idx), wdata: 32'd0});
         exp_fill_q.push_back('{idx: 3'(idx), data: mem_fn(base + 32'(4 * idx))});
      end
      exp_crit_q.push_back(mem_fn(base + 32'(4 * crit)));
      exp_done++;
      miss_valid   = 1'b1;
      miss_addr    = addr;
      victim_dirty = dirty;
      victim_addr  = vaddr;
      @(posedge clk);
      #1;
      miss_valid   = 1'b0;
      miss_addr    = $urandom;
      victim_dirty = $urandom_range(0, 1);
      victim_addr  = $urandom;
   endtask

   task automatic wait_done();
      bit ok;
      ok = 0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         ok = (done_cnt >= exp_done);
      end
      chk("done_timeout", 64'(ok), 64'(1));
      chk("req_q_drained", 64'(exp_req_q.size()), 64'(0));
      chk("fill_q_drained", 64'(exp_fill_q.size()), 64'(0));
      chk("crit_q_drained", 64'(exp_crit_q.size()), 64'(0));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_miss_ready"}, 64'(miss_ready), 64'(1));
      chk({tag, "_req_valid"}, 64'(mem_req_valid), 64'(0));
      chk({tag, "_req_addr"}, 64'(mem_req_addr), 64'(0));
      chk({tag, "_req_wdata"}, 64'(mem_req_wdata), 64'(0));
      chk({tag, "_fill_valid"}, 64'(fill_valid), 64'(0));
      chk({tag, "_fill_idx_data"}, 64'({fill_idx, fill_data}), 64'(0));
      chk({tag, "_crit"}, 64'({crit_valid, crit_data}), 64'(0));
      chk({tag, "_done"}, 64'(refill_done), 64'(0));
      chk({tag, "_wb_idx"}, 64'(wb_rd_idx), 64'(0));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit ok;
      reset_n        = 1'b0;
      miss_valid     = 1'b0;
      miss_addr      = '0;
      victim_dirty   = 1'b0;
      victim_addr    = '0;
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      for (int k = 0; k < 8; k++) victim_words[k] = '0;
      repeat (3) @(posedge clk);
      #2;
      check_reset_outputs("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // clean miss, critical word 5, latency 2
      data_seed = $urandom;
      start_miss(32'h0000_1014, 1'b0, 32'h0, 2);
      wait_done();

      // dirty victim write-back then refill
      data_seed = $urandom;
      start_miss(32'h0000_3000, 1'b1, 32'h0000_2000, 2);
      wait_done();

      // request stalls mid write-back and mid read burst
      data_seed   = $urandom;
      stall_wr_at = wr_fires + 3;
      stall_rd_at = rd_fires + 3;
      start_miss(32'h0000_4A08, 1'b1, 32'h0000_7F20, 3);
      wait_done();

      // long latency: the outstanding limit must be reached but never exceeded
      data_seed = $urandom;
      peak_out  = 0;
      start_miss(32'h0001_001C, 1'b0, 32'h0, 10);
      wait_done();
      chk("peak_outstanding", 64'(peak_out), 64'(MAX_OUT));

      // reset during the read phase, after three fills
      data_seed = $urandom;
      ok = 0;
      start_miss(32'h0002_0024, 1'b0, 32'h0, 4);
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk);
         ok = (fills_seen >= 3 + 8 * 4);
      end
      chk("reset_wait_fills", 64'(ok), 64'(1));
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      exp_req_q.delete();
      exp_fill_q.delete();
      exp_crit_q.delete();
      mem_q.delete();
      outstanding = 0;
      exp_done    = done_cnt;
      @(posedge clk);
      #2;
      reset_n = 1'b1;

      // stray responses while idle must be ignored
      spur_cnt = 3;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("spur_no_fill", 64'({fill_valid, crit_valid}), 64'(0));
      end

      data_seed = $urandom;
      start_miss(32'h0002_0024, 1'b1, 32'h0005_5540, 3);
      wait_done();

      // randomized misses, random latency and ready back-pressure
      rand_ready = 1;
      for (int n = 0; n < 12; n++) begin
         data_seed = $urandom;
         start_miss($urandom, bit'($urandom_range(0, 1)), $urandom & ~32'd31, int'($urandom_range(1, 8)));
         wait_done();
      end

      repeat (10) @(negedge clk);
      chk("done_count", 64'(done_cnt), 64'(exp_done));
      chk("no_stray_outstanding", 64'(outstanding), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
